// File: rtl/multi_lane_fifo_pkg.sv
// Shared defaults and pointer-width helper for the multi-lane FIFO.
package multi_lane_fifo_pkg;

  localparam int K_DWIDTH_DEF = 4;
  localparam int K_NLANE_DEF  = 4;
  localparam int K_DEPTH_DEF  = 8;

  // Pointer width: index bits plus one wrap bit to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// Ring pointer with wrap bit; index wraps K_DEPTH-1 -> 0 and toggles the wrap bit.
module ring_ptr
  import multi_lane_fifo_pkg::*;
#(
  parameter int K_DEPTH = K_DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_inc,
  output logic [$clog2(K_DEPTH):0] o_ptr
);

  localparam int PW = ptr_width(K_DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: clear wins over increment; explicit wrap at the last index.
  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_inc) begin
      if (ptr_q[IW-1:0] == IW'(K_DEPTH - 1)) begin
        ptr_d = {~ptr_q[IW], {IW{1'b0}}};
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/multi_lane_fifo.sv
// Multi-lane synchronous FIFO: per-lane valid masks, valid/ready on both
// sides, synchronous flush, registered occupancy and sticky write-stall flag.
module multi_lane_fifo
  import multi_lane_fifo_pkg::*;
#(
  parameter int K_DWIDTH = K_DWIDTH_DEF,
  parameter int K_NLANE  = K_NLANE_DEF,
  parameter int K_DEPTH  = K_DEPTH_DEF
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_flush,
  input  logic                              i_wr_valid,
  output logic                              o_wr_ready,
  input  logic [K_NLANE-1:0][K_DWIDTH-1:0]  i_wr_data,
  input  logic [K_NLANE-1:0]                i_wr_lane_en,
  output logic                              o_rd_valid,
  input  logic                              i_rd_ready,
  output logic [K_NLANE-1:0][K_DWIDTH-1:0]  o_rd_data,
  output logic [K_NLANE-1:0]                o_rd_lane_vld,
  output logic [$clog2(K_DEPTH):0]          o_count,
  output logic                              o_wr_stall
);

  localparam int PW = ptr_width(K_DEPTH);
  localparam int IW = PW - 1;

  typedef logic [K_DWIDTH-1:0] lane_t;
  typedef lane_t [K_NLANE-1:0] entry_t;

  entry_t             mem_q  [K_DEPTH];
  logic [K_NLANE-1:0] mask_q [K_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;
  logic          stall_q;
  logic          stall_d;
  logic          full;
  logic          empty;
  logic          wr_fire;
  logic          rd_fire;
  entry_t        wr_entry;

  assign full    = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_fire = i_wr_valid & ~full  & ~i_flush;
  assign rd_fire = i_rd_ready & ~empty & ~i_flush;

  ring_ptr #(.K_DEPTH(K_DEPTH)) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (wr_fire),
    .o_ptr   (wr_ptr)
  );

  ring_ptr #(.K_DEPTH(K_DEPTH)) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (rd_fire),
    .o_ptr   (rd_ptr)
  );

  // Disabled lanes are zeroed on the way in so the read side needs no masking.
  for (genvar gi = 0; gi < K_NLANE; gi++) begin : g_lane
    assign wr_entry[gi] = i_wr_lane_en[gi] ? i_wr_data[gi] : '0;
  end

  // Occupancy and sticky stall next-state; flush overrides everything.
  always_comb begin
    count_d = count_q;
    stall_d = stall_q | (i_wr_valid & full);
    if (i_flush) begin
      count_d = '0;
      stall_d = 1'b0;
    end else if (wr_fire && !rd_fire) begin
      count_d = count_q + 1'b1;
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - 1'b1;
    end
  end

  // Status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Entry storage; flush leaves contents alone, reset clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < K_DEPTH; i++) begin
        mem_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[wr_ptr[IW-1:0]]  <= wr_entry;
      mask_q[wr_ptr[IW-1:0]] <= i_wr_lane_en;
    end
  end

  assign o_wr_ready    = ~full;
  assign o_rd_valid    = ~empty;
  assign o_rd_data     = mem_q[rd_ptr[IW-1:0]];
  assign o_rd_lane_vld = mask_q[rd_ptr[IW-1:0]];
  assign o_count       = count_q;
  assign o_wr_stall    = stall_q;

endmodule

// File: tb/tb_multi_lane_fifo.sv
// Bench for multi_lane_fifo: default instance (4x4 bits, depth 8) driven by a
// constant table, hand sequences and random traffic against a queue model;
// a second instance (3x8 bits, depth 2) exercises a non-default geometry.
module tb_multi_lane_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default instance
  logic        d_flush, d_wv, d_rr;
  logic [15:0] d_wdata;
  logic [3:0]  d_en;
  logic        d_wr_ready, d_rd_valid, d_stall;
  logic [15:0] d_rd_data;
  logic [3:0]  d_lane;
  logic [3:0]  d_count;

  // small instance
  logic        s_flush, s_wv, s_rr;
  logic [23:0] s_wdata;
  logic [2:0]  s_en;
  logic        s_wr_ready, s_rd_valid, s_stall;
  logic [23:0] s_rd_data;
  logic [2:0]  s_lane;
  logic [1:0]  s_count;

  multi_lane_fifo #(.K_DWIDTH(4), .K_NLANE(4), .K_DEPTH(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(d_flush),
    .i_wr_valid(d_wv), .o_wr_ready(d_wr_ready), .i_wr_data(d_wdata), .i_wr_lane_en(d_en),
    .o_rd_valid(d_rd_valid), .i_rd_ready(d_rr), .o_rd_data(d_rd_data), .o_rd_lane_vld(d_lane),
    .o_count(d_count), .o_wr_stall(d_stall)
  );

  multi_lane_fifo #(.K_DWIDTH(8), .K_NLANE(3), .K_DEPTH(2)) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(s_flush),
    .i_wr_valid(s_wv), .o_wr_ready(s_wr_ready), .i_wr_data(s_wdata), .i_wr_lane_en(s_en),
    .o_rd_valid(s_rd_valid), .i_rd_ready(s_rr), .o_rd_data(s_rd_data), .o_rd_lane_vld(s_lane),
    .o_count(s_count), .o_wr_stall(s_stall)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of (masked data, mask) pairs.
  logic [15:0] mq_data[$];
  logic [3:0]  mq_mask[$];
  bit          m_stall;

  function automatic logic [15:0] mask16(input logic [15:0] d, input logic [3:0] e);
    logic [15:0] r;
    r = d;
    for (int l = 0; l < 4; l++) if (!e[l]) r[4*l +: 4] = 4'h0;
    return r;
  endfunction

  task automatic model_check(input string tag);
    check({tag, ".count"},    32'(d_count),    32'(mq_data.size()));
    check({tag, ".wr_ready"}, 32'(d_wr_ready), 32'(mq_data.size() < 8));
    check({tag, ".rd_valid"}, 32'(d_rd_valid), 32'(mq_data.size() > 0));
    check({tag, ".stall"},    32'(d_stall),    32'(m_stall));
    if (mq_data.size() > 0) begin
      check({tag, ".rd_data"}, 32'(d_rd_data), 32'(mq_data[0]));
      check({tag, ".lane_vld"}, 32'(d_lane),   32'(mq_mask[0]));
    end
  endtask

  // One clock cycle on the default instance, checked against the model.
  task automatic run_cycle(input bit fl, input bit wv, input logic [15:0] data,
                           input logic [3:0] en, input bit rr);
    bit          wrdy, rv, wfire, rfire;
    logic [15:0] rdat;
    d_flush = fl; d_wv = wv; d_wdata = data; d_en = en; d_rr = rr;
    model_check("model");
    wrdy  = mq_data.size() < 8;
    rv    = mq_data.size() > 0;
    wfire = !fl && wv && wrdy;
    rfire = !fl && rr && rv;
    rdat  = rv ? mq_data[0] : 16'h0;
    @(posedge clk); #1;
    if (fl) begin
      mq_data.delete(); mq_mask.delete(); m_stall = 0;
    end else begin
      if (wv && !wrdy) m_stall = 1;
      if (rfire) begin void'(mq_data.pop_front()); void'(mq_mask.pop_front()); end
      if (wfire) begin mq_data.push_back(mask16(data, en)); mq_mask.push_back(en); end
    end
    if (fl || wfire || rfire)
      $display("txn: flush=%0b wr=%0b data=%h en=%b rd=%0b data=%h count=%0d",
               fl, wfire, data, en, rfire, rdat, mq_data.size());
  endtask

  // Small instance: apply inputs for one edge.
  task automatic s_cycle(input bit wv, input logic [23:0] data, input logic [2:0] en, input bit rr);
    s_wv = wv; s_wdata = data; s_en = en; s_rr = rr;
    @(posedge clk); #1;
    s_wv = 0; s_rr = 0;
    $display("small txn: wr=%0b data=%h en=%b rd=%0b count=%0d", wv, data, en, rr, s_count);
  endtask

  typedef struct {
    bit          fl, wv, rr;
    logic [15:0] data;
    logic [3:0]  en;
    int          exp_count;
    bit          exp_rv, exp_wr, exp_stall;
    logic [15:0] exp_data;
    logic [3:0]  exp_lane;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // fill 8, held 9th write, drain 8, flush, masked write, read
    for (int i = 0; i < 8; i++)
      vecs[i] = '{0, 1, 0, 16'(32'h1111 * (i + 1)), 4'hF, i + 1, 1, (i < 7), 0, 16'h1111, 4'hF};
    vecs[8] = '{0, 1, 0, 16'h9999, 4'hF, 8, 1, 0, 1, 16'h1111, 4'hF};
    for (int k = 0; k < 8; k++)
      vecs[9 + k] = '{0, 0, 1, 16'h0, 4'h0, 7 - k, (k < 7), 1, 1, 16'(32'h1111 * (k + 2)), 4'hF};
    vecs[17] = '{1, 0, 0, 16'h0, 4'h0, 0, 0, 1, 0, 16'h0, 4'h0};
    vecs[18] = '{0, 1, 0, 16'hABCD, 4'b0101, 1, 1, 1, 0, 16'h0B0D, 4'b0101};
    vecs[19] = '{0, 0, 1, 16'h0, 4'h0, 0, 0, 1, 0, 16'h0, 4'h0};

    d_flush = 0; d_wv = 0; d_wdata = '0; d_en = '0; d_rr = 0;
    s_flush = 0; s_wv = 0; s_wdata = '0; s_en = '0; s_rr = 0;
    m_stall = 0;
    rst_n = 0;
    #1;
    check("reset.wr_ready", 32'(d_wr_ready), 32'd1);
    check("reset.rd_valid", 32'(d_rd_valid), 32'd0);
    check("reset.rd_data",  32'(d_rd_data),  32'd0);
    check("reset.lane_vld", 32'(d_lane),     32'd0);
    check("reset.count",    32'(d_count),    32'd0);
    check("reset.stall",    32'(d_stall),    32'd0);
    check("reset.small_wr_ready", 32'(s_wr_ready), 32'd1);
    check("reset.small_rd_data",  32'(s_rd_data),  32'd0);
    #20;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // table vectors
    for (int v = 0; v < 20; v++) begin
      run_cycle(vecs[v].fl, vecs[v].wv, vecs[v].data, vecs[v].en, vecs[v].rr);
      check($sformatf("vec%0d.count", v),    32'(d_count),    32'(vecs[v].exp_count));
      check($sformatf("vec%0d.rd_valid", v), 32'(d_rd_valid), 32'(vecs[v].exp_rv));
      check($sformatf("vec%0d.wr_ready", v), 32'(d_wr_ready), 32'(vecs[v].exp_wr));
      check($sformatf("vec%0d.stall", v),    32'(d_stall),    32'(vecs[v].exp_stall));
      if (vecs[v].exp_rv) begin
        check($sformatf("vec%0d.rd_data", v),  32'(d_rd_data), 32'(vecs[v].exp_data));
        check($sformatf("vec%0d.lane_vld", v), 32'(d_lane),    32'(vecs[v].exp_lane));
      end
    end

    // count held at 3 across two pointer wraps
    for (int i = 0; i < 3; i++) run_cycle(0, 1, 16'(32'hC000 + i), 4'hF, 0);
    for (int i = 0; i < 20; i++) begin
      run_cycle(0, 1, 16'($urandom), 4'($urandom), 1);
      check("wrap.count", 32'(d_count), 32'd3);
    end

    // flush at count 5 with concurrent write and read
    run_cycle(0, 1, 16'h5A5A, 4'hF, 0);
    run_cycle(0, 1, 16'hA5A5, 4'hF, 0);
    check("preflush.count", 32'(d_count), 32'd5);
    run_cycle(1, 1, 16'h7777, 4'hF, 1);
    check("flush.count",    32'(d_count),    32'd0);
    check("flush.rd_valid", 32'(d_rd_valid), 32'd0);
    check("flush.stall",    32'(d_stall),    32'd0);
    run_cycle(0, 0, 16'h0, 4'h0, 0);
    check("postflush.rd_valid", 32'(d_rd_valid), 32'd0);

    // random traffic: write-heavy then read-heavy, rare flushes
    for (int i = 0; i < 400; i++) begin
      bit fl, wv, rr;
      fl = ($urandom_range(0, 39) == 0);
      if (i < 200) begin
        wv = ($urandom_range(0, 3) != 0); rr = ($urandom_range(0, 2) == 0);
      end else begin
        wv = ($urandom_range(0, 2) == 0); rr = ($urandom_range(0, 3) != 0);
      end
      run_cycle(fl, wv, 16'($urandom), 4'($urandom), rr);
    end
    model_check("final");

    // asynchronous reset between clock edges
    run_cycle(0, 1, 16'h1234, 4'hF, 0);
    run_cycle(0, 1, 16'h5678, 4'hF, 0);
    d_wv = 0; d_rr = 0;
    #2;
    rst_n = 0;
    #1;
    check("async_rst.count",    32'(d_count),    32'd0);
    check("async_rst.rd_valid", 32'(d_rd_valid), 32'd0);
    check("async_rst.wr_ready", 32'(d_wr_ready), 32'd1);
    check("async_rst.rd_data",  32'(d_rd_data),  32'd0);
    check("async_rst.stall",    32'(d_stall),    32'd0);
    mq_data.delete(); mq_mask.delete(); m_stall = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // small geometry: fill, read one, write one, drain
    s_cycle(1, 24'h112233, 3'b111, 0);
    check("small.w1.count", 32'(s_count), 32'd1);
    check("small.w1.data",  32'(s_rd_data), 32'h112233);
    check("small.w1.lane",  32'(s_lane), 32'h7);
    s_cycle(1, 24'h445566, 3'b011, 0);
    check("small.w2.count",    32'(s_count), 32'd2);
    check("small.w2.wr_ready", 32'(s_wr_ready), 32'd0);
    check("small.w2.data",     32'(s_rd_data), 32'h112233);
    s_cycle(0, 24'h0, 3'b000, 1);
    check("small.r1.count", 32'(s_count), 32'd1);
    check("small.r1.data",  32'(s_rd_data), 32'h005566);
    check("small.r1.lane",  32'(s_lane), 32'h3);
    s_cycle(1, 24'h778899, 3'b101, 0);
    check("small.w3.count",    32'(s_count), 32'd2);
    check("small.w3.wr_ready", 32'(s_wr_ready), 32'd0);
    s_cycle(0, 24'h0, 3'b000, 1);
    check("small.r2.data", 32'(s_rd_data), 32'h770099);
    check("small.r2.lane", 32'(s_lane), 32'h5);
    s_cycle(0, 24'h0, 3'b000, 1);
    check("small.r3.count",    32'(s_count), 32'd0);
    check("small.r3.rd_valid", 32'(s_rd_valid), 32'd0);
    check("small.stall",       32'(s_stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_lane_fifo.md
# multi_lane_fifo

Parametrised multi-lane synchronous FIFO that buffers a packed array of K_NLANE words of K_DWIDTH bits, with per-lane valid tracking, valid/ready handshakes on both sides, synchronous flush and occupancy reporting. It generalises the fixed four-lane packed memory input used by the datapath front-end into a configurable-depth elastic buffer between a lane-oriented producer and consumer.

## Interface
Parameters:
- K_DWIDTH, 4, bits per lane word (>=1)
- K_NLANE, 4, number of lanes per entry (>=1)
- K_DEPTH, 8, number of entries; power of two, >=2

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_flush  in  1  synchronous flush: empties FIFO, clears sticky flag
- i_wr_valid  in  1  producer has an entry
- o_wr_ready  out  1  FIFO accepts an entry (= not full)
- i_wr_data  in  [K_NLANE-1:0][K_DWIDTH-1:0]  entry payload, lane 0 in bits [K_DWIDTH-1:0]
- i_wr_lane_en  in  [K_NLANE-1:0]  lanes carrying valid data in this entry
- o_rd_valid  out  1  head entry available (= not empty)
- i_rd_ready  in  1  consumer takes head entry
- o_rd_data  out  [K_NLANE-1:0][K_DWIDTH-1:0]  head entry payload; disabled lanes read 0
- o_rd_lane_vld  out  [K_NLANE-1:0]  lane enables stored with head entry
- o_count  out  $clog2(K_DEPTH)+1  current occupancy, 0..K_DEPTH
- o_wr_stall  out  1  sticky: i_wr_valid seen while o_wr_ready low

## Operation
- Write fires when i_wr_valid & o_wr_ready; read fires when o_rd_valid & i_rd_ready.
- On write, lane l stores i_wr_data[l] if i_wr_lane_en[l], else 0; enable mask stored alongside.
- Write with i_wr_lane_en == 0 is legal: stores an all-invalid entry, counts toward o_count.
- Pointers: wr_ptr/rd_ptr of $clog2(K_DEPTH)+1 bits (extra wrap bit). Full when indices equal and wrap bits differ; empty when fully equal. Index wraps K_DEPTH-1 -> 0, toggling wrap bit.
- o_count = wr_ptr - rd_ptr, modulo 2^($clog2(K_DEPTH)+1); registered, updated +1 write-only, -1 read-only, unchanged on both or neither.
- Simultaneous write and read with 0 < count < K_DEPTH: both fire, count unchanged.
- Full: o_wr_ready=0; no write-through even if read fires same cycle.
- Empty: o_rd_valid=0; no read-through of data being written same cycle.
- o_wr_stall sets on any cycle i_wr_valid & !o_wr_ready; holds until i_flush or reset.
- i_flush priority over read and write in the same cycle: pointers, count, o_wr_stall to 0; concurrent write and read are dropped; storage contents untouched.
- Reset: pointers, count, o_wr_stall, storage (data and masks) to 0.

## Timing
- Reset values: o_wr_ready=1, o_rd_valid=0, o_rd_data=0, o_rd_lane_vld=0, o_count=0, o_wr_stall=0.
- Write-to-read latency: entry written at edge N gives o_rd_valid=1 and its data from edge N onward (one cycle after the producer presented it).
- o_rd_data/o_rd_lane_vld are a combinational mux of storage at rd_ptr index; stable while o_rd_valid & !i_rd_ready.
- Throughput: one write and one read per cycle sustained when neither full nor empty.
- o_wr_ready, o_rd_valid, o_count derive only from registered state; no combinational path from i_rd_ready to o_wr_ready or from i_wr_valid to o_rd_valid.
- Reset asserted mid-transfer: all state clears immediately (asynchronously); the in-flight transfer is lost.

## Structure
- Package multi_lane_fifo_pkg: default constants K_DWIDTH_DEF, K_NLANE_DEF, K_DEPTH_DEF and a function for pointer width; module-specific packed types (lane word, entry) declared in the module since they depend on parameters.
- One sub-module ring_ptr (parameter K_DEPTH; ports i_clk, i_rst_n, i_clr, i_inc, o_ptr with wrap bit), instantiated twice for write and read pointers.
- Storage: unpacked array [K_DEPTH] of packed entry plus unpacked array [K_DEPTH] of lane mask.

## Test plan
- Reset with defaults, then 8 writes of distinct data, mask 4'b1111, rd_ready=0 -> o_count 1..8, o_wr_ready=0 after 8th; 9th write held, o_wr_stall=1.
- Drain 8 entries with rd_ready=1 -> data returned in write order, o_count 8..0, o_rd_valid=0 after last.
- Write data 16'hABCD with mask 4'b0101 -> o_rd_data=16'h0B0D, o_rd_lane_vld=4'b0101.
- Count held at 3, simultaneous write and read for 20 cycles (pointers wrap twice) -> o_count stays 3, order preserved across wrap.
- Count 5, i_flush together with i_wr_valid and i_rd_ready -> next cycle o_count=0, o_rd_valid=0, o_wr_stall=0, no entry written.
- K_DWIDTH=8, K_NLANE=3, K_DEPTH=2: fill, read one, write one -> full again, read sequence matches writes.
